// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and framing constants.
`timescale 1ns/1ps
package uart_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_MIN_BIT_LENGTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RECV_DATA,
        RECV_PARITY,
        RECV_STOP_BIT,
        RECV_STOP_BIT_2,
        FINISH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the serial line with a falling-edge detect.
// Flops reset to 1 so an idle line never looks like a start edge after reset.
`timescale 1ns/1ps
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic rx_s,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_rx};
            rx_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-sampled frames with optional parity, one or two stop
// bits, a one-entry output register with valid/ready, and RTS flow control.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_rx,
    output logic           o_rts,
    input  logic           i_hw_flow_control_enable,
    input  logic [31:0]    i_bit_length,
    input  logic           i_msb_first,
    input  logic           i_parity_enable,
    input  logic           i_parity_odd,
    input  logic           i_two_stop_bits,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [7:0]     o_data,
    output logic           o_parity_err,
    output logic           o_frame_err,
    output logic           o_overrun,
    output uart_rx_state_t o_dbg_state
);

    // Handshake: a frame transfers on any clock edge where o_valid && i_ready;
    // o_data and the flags hold steady while o_valid && !i_ready.

    logic           rx_s, rx_fall;
    uart_rx_state_t state, state_n;
    logic [31:0]    cnt, cnt_n;
    logic [31:0]    bl_q;
    logic           msb_q, par_en_q, par_odd_q, two_stop_q;
    logic [2:0]     bit_idx;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic           perr_q, ferr_q;
    logic           expired, start_frame, sample, deliver;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_rx    (i_rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    assign expired = (cnt == 32'd0);

    // Counter is loaded with (interval - 1) so it hits zero exactly on the sample cycle.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        start_frame = 1'b0;
        sample      = 1'b0;
        deliver     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall && (i_bit_length >= 32'(UART_MIN_BIT_LENGTH))) begin
                    start_frame = 1'b1;
                    cnt_n       = (i_bit_length >> 1) - 32'd1;
                    state_n     = START;
                end
            end
            START: begin
                if (!expired) cnt_n = cnt - 32'd1;
                else if (rx_s) state_n = IDLE;
                else begin
                    cnt_n   = bl_q - 32'd1;
                    state_n = RECV_DATA;
                end
            end
            RECV_DATA: begin
                if (!expired) cnt_n = cnt - 32'd1;
                else begin
                    sample = 1'b1;
                    cnt_n  = bl_q - 32'd1;
                    if (bit_idx == 3'd7) state_n = par_en_q ? RECV_PARITY : RECV_STOP_BIT;
                end
            end
            RECV_PARITY: begin
                if (!expired) cnt_n = cnt - 32'd1;
                else begin
                    sample  = 1'b1;
                    cnt_n   = bl_q - 32'd1;
                    state_n = RECV_STOP_BIT;
                end
            end
            RECV_STOP_BIT: begin
                if (!expired) cnt_n = cnt - 32'd1;
                else begin
                    sample  = 1'b1;
                    cnt_n   = bl_q - 32'd1;
                    state_n = two_stop_q ? RECV_STOP_BIT_2 : FINISH;
                end
            end
            RECV_STOP_BIT_2: begin
                if (!expired) cnt_n = cnt - 32'd1;
                else begin
                    sample  = 1'b1;
                    state_n = FINISH;
                end
            end
            FINISH: begin
                deliver = 1'b1;
                cnt_n   = 32'd0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            bl_q         <= 32'd0;
            msb_q        <= 1'b0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            two_stop_q   <= 1'b0;
            bit_idx      <= 3'd0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            o_overrun <= 1'b0;
            if (start_frame) begin
                bl_q       <= i_bit_length;
                msb_q      <= i_msb_first;
                par_en_q   <= i_parity_enable;
                par_odd_q  <= i_parity_odd;
                two_stop_q <= i_two_stop_bits;
                bit_idx    <= 3'd0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
            end
            if (sample) begin
                case (state)
                    RECV_DATA: begin
                        if (msb_q) shift_q[~bit_idx] <= rx_s;
                        else       shift_q[bit_idx]  <= rx_s;
                        bit_idx <= bit_idx + 3'd1;
                    end
                    RECV_PARITY: perr_q <= ((^shift_q) ^ rx_s) != par_odd_q;
                    RECV_STOP_BIT, RECV_STOP_BIT_2: if (!rx_s) ferr_q <= 1'b1;
                    default: ;
                endcase
            end
            // A full holding register with no taker keeps the old frame; the new one is lost.
            if (deliver) begin
                if (!o_valid || i_ready) begin
                    o_valid      <= 1'b1;
                    o_data       <= shift_q;
                    o_parity_err <= perr_q;
                    o_frame_err  <= ferr_q;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid      <= 1'b0;
                o_parity_err <= 1'b0;
                o_frame_err  <= 1'b0;
            end
        end
    end

    assign o_rts       = i_hw_flow_control_enable ? !o_valid : 1'b1;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: per-scenario tasks drive serial frames; a monitor pops
// expected {data, perr, ferr} entries from a queue on every accepted frame.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int SYNC = 2;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_rx;
    logic           o_rts;
    logic           i_hw_flow_control_enable;
    logic [31:0]    i_bit_length;
    logic           i_msb_first;
    logic           i_parity_enable;
    logic           i_parity_odd;
    logic           i_two_stop_bits;
    logic           o_valid;
    logic           i_ready;
    logic [7:0]     o_data;
    logic           o_parity_err;
    logic           o_frame_err;
    logic           o_overrun;
    uart_rx_state_t o_dbg_state;

    uart_rx #(.SYNC_STAGES(SYNC)) dut (
        .i_clk                    (i_clk),
        .i_rst                    (i_rst),
        .i_rx                     (i_rx),
        .o_rts                    (o_rts),
        .i_hw_flow_control_enable (i_hw_flow_control_enable),
        .i_bit_length             (i_bit_length),
        .i_msb_first              (i_msb_first),
        .i_parity_enable          (i_parity_enable),
        .i_parity_odd             (i_parity_odd),
        .i_two_stop_bits          (i_two_stop_bits),
        .o_valid                  (o_valid),
        .i_ready                  (i_ready),
        .o_data                   (o_data),
        .o_parity_err             (o_parity_err),
        .o_frame_err              (o_frame_err),
        .o_overrun                (o_overrun),
        .o_dbg_state              (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    int         n_total     = 0;
    int         n_pass      = 0;
    int         overrun_cnt = 0;
    int         frames_seen = 0;
    bit         mon_en      = 1'b0;
    logic [9:0] exp_q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge i_clk) begin
        logic [9:0] e;
        #1;
        if (mon_en && !i_rst) begin
            if (o_overrun) overrun_cnt++;
            n_total++;
            if (!o_valid && (o_parity_err || o_frame_err))
                $display("FAIL idle_flags: got perr=%0b ferr=%0b with o_valid=0, required 0/0", o_parity_err, o_frame_err);
            else n_pass++;
            if (o_valid && i_ready) begin
                frames_seen++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_frame: got data=%02h perr=%0b ferr=%0b, required no frame",
                             o_data, o_parity_err, o_frame_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_data, o_parity_err, o_frame_err} !== e)
                        $display("FAIL frame: got data=%02h perr=%0b ferr=%0b, required data=%02h perr=%0b ferr=%0b",
                                 o_data, o_parity_err, o_frame_err, e[9:2], e[1], e[0]);
                    else n_pass++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_bit(input logic b, input int len);
        i_rx = b;
        repeat (len) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop1);
        int len;
        len = int'(i_bit_length);
        send_bit(1'b0, len);
        for (int k = 0; k < 8; k++) send_bit(i_msb_first ? d[7-k] : d[k], len);
        if (i_parity_enable) send_bit(pbit, len);
        send_bit(stop1, len);
        if (i_two_stop_bits) send_bit(1'b1, len);
    endtask

    function automatic logic model_perr(input logic [7:0] d, input logic pbit);
        if (!i_parity_enable) return 1'b0;
        return (((^d) ^ pbit) != i_parity_odd);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        n_total++;
        if ({o_valid, o_data, o_parity_err, o_frame_err, o_overrun} !== 12'h0)
            $display("FAIL reset_outputs: got v=%0b d=%02h pe=%0b fe=%0b ov=%0b, required all 0",
                     o_valid, o_data, o_parity_err, o_frame_err, o_overrun);
        else n_pass++;
        n_total++;
        if (o_dbg_state !== IDLE || o_rts !== 1'b1)
            $display("FAIL reset_state: got state=%0d rts=%0b, required state=IDLE rts=1", o_dbg_state, o_rts);
        else n_pass++;
        i_rst = 1'b0;
        idle(5);
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        i_bit_length = 16; i_msb_first = 0; i_parity_enable = 0; i_two_stop_bits = 0; i_ready = 1;
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                lat = 0;
                while (!o_valid && lat < 400) begin
                    @(negedge i_clk);
                    lat++;
                end
                n_total++;
                if (lat !== 154 + SYNC) $display("FAIL basic_latency: got %0d cycles, required %0d", lat, 154 + SYNC);
                else n_pass++;
                @(negedge i_clk);
                n_total++;
                if (o_valid !== 1'b0) $display("FAIL basic_valid_width: got o_valid=%0b one cycle later, required 0", o_valid);
                else n_pass++;
            end
        join
        idle(10);
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic       pb;
        i_bit_length = 16; i_msb_first = 1; i_parity_enable = 1; i_parity_odd = 0; i_two_stop_bits = 1;
        exp_q.push_back({8'h3C, model_perr(8'h3C, 1'b0), 1'b0});
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(20);
        exp_q.push_back({8'h3C, model_perr(8'h3C, 1'b1), 1'b0});
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(20);
        i_parity_odd = 1; i_msb_first = 0;
        for (int i = 0; i < 3; i++) begin
            d  = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            exp_q.push_back({d, model_perr(d, pb), 1'b0});
            send_frame(d, pb, 1'b1);
            idle(10);
        end
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL parity_drain: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_frame_err_break();
        int f0;
        i_bit_length = 8; i_msb_first = 0; i_parity_enable = 0; i_two_stop_bits = 0;
        f0 = frames_seen;
        exp_q.push_back({8'h55, 1'b0, 1'b1});
        send_frame(8'h55, 1'b0, 1'b0);
        idle(40);
        n_total++;
        if (frames_seen - f0 !== 1) $display("FAIL break_frames: got %0d frames, required 1", frames_seen - f0);
        else n_pass++;
        i_rx = 1'b1;
        idle(20);
        exp_q.push_back({8'h12, 1'b0, 1'b0});
        send_frame(8'h12, 1'b0, 1'b1);
        idle(20);
        n_total++;
        if (frames_seen - f0 !== 2) $display("FAIL after_break_frames: got %0d frames, required 2", frames_seen - f0);
        else n_pass++;
    endtask

    task automatic test_overrun_flow();
        int ov0;
        i_bit_length = 16; i_msb_first = 0; i_parity_enable = 0; i_two_stop_bits = 0;
        i_hw_flow_control_enable = 1; i_ready = 0;
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 1'b0, 1'b1);
        idle(10);
        n_total++;
        if (o_valid !== 1'b1 || o_rts !== 1'b0 || o_data !== 8'h11)
            $display("FAIL hold_first: got v=%0b rts=%0b d=%02h, required v=1 rts=0 d=11", o_valid, o_rts, o_data);
        else n_pass++;
        ov0 = overrun_cnt;
        send_frame(8'h22, 1'b0, 1'b1);
        idle(10);
        n_total++;
        if (overrun_cnt - ov0 !== 1) $display("FAIL overrun_pulse: got %0d cycles, required 1", overrun_cnt - ov0);
        else n_pass++;
        n_total++;
        if (o_data !== 8'h11 || o_valid !== 1'b1 || o_rts !== 1'b0)
            $display("FAIL overrun_hold: got d=%02h v=%0b rts=%0b, required d=11 v=1 rts=0", o_data, o_valid, o_rts);
        else n_pass++;
        i_hw_flow_control_enable = 0;
        #1;
        n_total++;
        if (o_rts !== 1'b1) $display("FAIL rts_disabled: got %0b, required 1", o_rts);
        else n_pass++;
        i_hw_flow_control_enable = 1;
        @(negedge i_clk);
        i_ready = 1;
        @(negedge i_clk);
        n_total++;
        if (o_valid !== 1'b0 || o_rts !== 1'b1)
            $display("FAIL drain_rts: got v=%0b rts=%0b, required v=0 rts=1", o_valid, o_rts);
        else n_pass++;
        i_hw_flow_control_enable = 0;
        idle(5);
    endtask

    task automatic test_glitch_reset();
        int f0;
        i_bit_length = 16; i_msb_first = 0; i_parity_enable = 0; i_two_stop_bits = 0; i_ready = 1;
        f0 = frames_seen;
        i_rx = 1'b0;
        idle(4);
        i_rx = 1'b1;
        idle(2);
        n_total++;
        if (o_dbg_state !== START) $display("FAIL glitch_start: got state=%0d, required START", o_dbg_state);
        else n_pass++;
        idle(30);
        n_total++;
        if (o_dbg_state !== IDLE || frames_seen !== f0)
            $display("FAIL glitch_idle: got state=%0d frames=%0d, required IDLE and %0d", o_dbg_state, frames_seen, f0);
        else n_pass++;
        fork
            send_frame(8'hF0, 1'b0, 1'b1);
            begin
                repeat (6 * 16 + 8) @(negedge i_clk);
                i_rst = 1'b1;
                repeat (3) @(negedge i_clk);
                i_rst = 1'b0;
                @(negedge i_clk);
                n_total++;
                if (o_dbg_state !== IDLE || o_valid !== 1'b0)
                    $display("FAIL midframe_reset: got state=%0d v=%0b, required IDLE v=0", o_dbg_state, o_valid);
                else n_pass++;
            end
        join
        idle(20);
        n_total++;
        if (frames_seen !== f0) $display("FAIL reset_no_output: got %0d frames, required %0d", frames_seen, f0);
        else n_pass++;
        exp_q.push_back({8'h0F, 1'b0, 1'b0});
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(20);
        n_total++;
        if (frames_seen !== f0 + 1) $display("FAIL after_reset_frame: got %0d frames, required %0d", frames_seen, f0 + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ov0;
        i_bit_length = 16; i_msb_first = 0; i_parity_enable = 0; i_two_stop_bits = 0; i_ready = 0;
        exp_q.push_back({8'h77, 1'b0, 1'b0});
        send_frame(8'h77, 1'b0, 1'b1);
        idle(10);
        ov0 = overrun_cnt;
        exp_q.push_back({8'h88, 1'b0, 1'b0});
        fork
            send_frame(8'h88, 1'b0, 1'b1);
            begin
                repeat (153 + SYNC) @(negedge i_clk);
                n_total++;
                if (o_dbg_state !== FINISH) $display("FAIL finish_timing: got state=%0d, required FINISH", o_dbg_state);
                else n_pass++;
                i_ready = 1;
                @(negedge i_clk);
                i_ready = 0;
                n_total++;
                if (o_valid !== 1'b1 || o_data !== 8'h88)
                    $display("FAIL same_cycle_load: got v=%0b d=%02h, required v=1 d=88", o_valid, o_data);
                else n_pass++;
            end
        join
        idle(5);
        n_total++;
        if (overrun_cnt !== ov0) $display("FAIL b2b_overrun: got %0d pulses, required 0", overrun_cnt - ov0);
        else n_pass++;
        i_ready = 1;
        idle(3);
        n_total++;
        if (exp_q.size() !== 0 || o_valid !== 1'b0)
            $display("FAIL b2b_drain: got pending=%0d v=%0b, required 0 and 0", exp_q.size(), o_valid);
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        i_rst = 1'b1; i_rx = 1'b1; i_ready = 1'b1;
        i_hw_flow_control_enable = 1'b0;
        i_bit_length = 32'd16; i_msb_first = 1'b0;
        i_parity_enable = 1'b0; i_parity_odd = 1'b0; i_two_stop_bits = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_frame_err_break();
        test_overrun_flow();
        test_glitch_reset();
        test_back_to_back();
        idle(5);
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the receive-side counterpart of the team's UART transmitter, sharing its run-time configuration (bit length in clocks, bit order, flow-control enable).
- Synchronises the asynchronous serial input and detects the start bit.
- Samples each bit at its centre; checks optional parity and one or two stop bits.
- Presents each received byte on a valid/ready output with per-frame error flags.
- Drives an RTS-style flow-control output.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in the i_rx synchroniser; legal values are 2 or more.

Ports:
- i_clk, input, 1: the single system clock.
- i_rst, input, 1: reset. Synchronous, active-high.
- i_rx, input, 1: asynchronous serial line; idles high.
- o_rts, output, 1: request-to-send; high means the block can accept a frame.
- i_hw_flow_control_enable, input, 1: enables RTS gating.
- i_bit_length, input, 32: clocks per bit.
- i_msb_first, input, 1: bit order; 1 means the first data bit received is bit 7.
- i_parity_enable, input, 1: a parity bit follows the data bits.
- i_parity_odd, input, 1: 1 selects odd parity, 0 selects even.
- i_two_stop_bits, input, 1: 1 expects two stop bits.
- o_valid, output, 1: o_data and the error flags hold a received frame.
- i_ready, input, 1: consumer accepts the frame.
- o_data, output, 8: received byte.
- o_parity_err, output, 1: parity mismatch for the presented frame.
- o_frame_err, output, 1: a stop bit was sampled low for the presented frame.
- o_overrun, output, 1: one-cycle pulse when a completed frame is dropped.

Behaviour:
Reset and synchronisation
- Synchronous, active-high: on i_rst the FSM goes to IDLE and the counters clear.
- Output reset values: o_valid=0, o_data=0, o_parity_err=0, o_frame_err=0, o_overrun=0.
- All synchroniser flops reset to 1.
- Reset mid-frame abandons the frame with no output.
- rx_s is the synchronised i_rx.

Configuration and edge cases
- i_bit_length, i_msb_first and the parity/stop settings are latched in the IDLE->START transition and are stable for the whole frame.
- i_bit_length < 2: the block stays in IDLE and ignores the line.

FSM (shared enum)
- IDLE: wait for a falling edge on rx_s (previous 1, current 0). On the edge, load the counter with i_bit_length>>1 and go to START.
- START: count down; at 0, sample rx_s.
  - Sample 1: glitch, go to IDLE with no output.
  - Sample 0: reload i_bit_length and go to RECV_DATA.
- RECV_DATA: each time the counter expires, sample one bit into the shift register; the position follows i_msb_first. After 8 bits, go to RECV_PARITY if parity is enabled, otherwise RECV_STOP_BIT.
- RECV_PARITY: sample the bit.
  - perr = XOR(data, parity bit) != i_parity_odd.
  - For even parity, the XOR of data and parity bit must be 0; for odd parity it must be 1.
- RECV_STOP_BIT: sample; a low sample sets ferr. Then go to RECV_STOP_BIT_2 if two stop bits, otherwise FINISH.
- RECV_STOP_BIT_2: sample; a low sample sets ferr. Go to FINISH.
- FINISH: a single cycle that delivers the frame, then go to IDLE.
  - Because IDLE requires a 1->0 edge, a line held low (break) never retriggers.

Timing
- The final sample is taken at the centre of the last stop bit.
- o_valid rises on the cycle after FINISH, i.e. 2 cycles after that final sample.
- Sample points relative to the edge cycle t0 (cycle rx_s first reads 0), with L=i_bit_length and H=L>>1:
  - start bit: t0+H
  - data bit k: t0+H+(k+1)·L

Output holding register (1 entry)
- In FINISH, if o_valid=0, or o_valid=1 and i_ready=1: load data, perr and ferr, and set o_valid=1.
- In FINISH, if o_valid=1 and i_ready=0: keep the old frame, drop the new one, and pulse o_overrun for 1 cycle.
- Outside FINISH, o_valid && i_ready clears o_valid the next cycle.
- While o_valid=0, the error flags are held at 0.
- o_data and the flags are stable while o_valid=1 && !i_ready.

Flow control
- o_rts = i_hw_flow_control_enable ? !o_valid : 1.
- o_rts is combinational from registered state.

Decomposition:
- uart_pkg: typedef uart_rx_state_t, with states IDLE, START, RECV_DATA, RECV_PARITY, RECV_STOP_BIT, RECV_STOP_BIT_2, FINISH (3-bit enum).
- uart_pkg: constants UART_DATA_BITS=8 and UART_MIN_BIT_LENGTH=2.
- Sub-module uart_rx_sync: a SYNC_STAGES-deep synchroniser with reset value 1, plus registered falling-edge detect. Outputs: rx_s and rx_fall.

Test Plan:
1. L=16, LSB-first, no parity, 1 stop, frame 0xA5, i_ready=1 -> o_valid for 1 cycle at t0+154 with o_data=0xA5 and both error flags 0.
2. L=16, MSB-first, even parity, 2 stop, frame 0x3C with correct parity bit 0 -> o_data=0x3C, perr=0. Repeat with parity bit 1 -> o_parity_err=1 and o_data=0x3C.
3. L=8, first stop bit driven low, byte 0x55 -> o_frame_err=1, o_data=0x55. Then hold the line low for 40 cycles -> no further o_valid. Then release and send 0x12 -> clean frame.
4. L=16, i_ready=0, frames 0x11 then 0x22 -> o_data stays 0x11, one o_overrun pulse. With flow control enabled, o_rts=0 while o_valid=1. Raise i_ready -> o_valid drops, o_rts=1.
5. L=16, 4-cycle low glitch on i_rx -> returns to IDLE with no o_valid. Assert i_rst mid-data during a frame 0xF0 -> no output; the next frame 0x0F is received correctly.
6. i_ready=1 in the same cycle as FINISH of a second frame (0x77 pending, 0x88 arriving) -> o_data=0x88, o_valid stays 1, no overrun.
